// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S transmitter.
package i2s_pkg;

    localparam int unsigned I2S_FMT_PHILIPS   = 1;
    localparam int unsigned I2S_FMT_LEFT_JUST = 0;

    function automatic int unsigned frame_len(input int unsigned data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: 50% duty BCLK with registered edge strobes.
module i2s_bclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic bclk_o,
    output logic bclk_posedge_o,
    output logic bclk_negedge_o,
    output logic fall_next_o
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_q, div_d;
    logic            bclk_q, bclk_d;
    logic            pos_q, pos_d;
    logic            neg_q, neg_d;
    logic            term;

    always_comb begin
        term   = (div_q == DivLast);
        div_d  = term ? '0 : div_q + DivW'(1);
        bclk_d = term ? ~bclk_q : bclk_q;
        pos_d  = term & ~bclk_q;
        neg_d  = term & bclk_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
            pos_q  <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
            pos_q  <= pos_d;
            neg_q  <= neg_d;
        end
    end

    // Lets the serializer update on the same edge that BCLK falls.
    assign fall_next_o    = term & bclk_q;
    assign bclk_o         = bclk_q;
    assign bclk_posedge_o = pos_q;
    assign bclk_negedge_o = neg_q;

endmodule

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: holding register, frame counter and serializer.
module i2s_master_tx
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned I2S_FORMAT = 1,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] left_i,
    input  logic [DATA_WIDTH-1:0] right_i,
    input  logic                  data_val_i,
    output logic                  data_rdy_o,
    output logic                  i2s_bclk_o,
    output logic                  i2s_lrclk_o,
    output logic                  i2s_data_o,
    output logic                  bclk_posedge_o,
    output logic                  bclk_negedge_o,
    output logic                  word_end_o,
    output logic                  underrun_o
);

    localparam int unsigned FrameLen = frame_len(DATA_WIDTH);
    localparam int unsigned CntW     = $clog2(FrameLen);
    localparam logic [CntW-1:0] CntLast = CntW'(FrameLen - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(DATA_WIDTH);

    logic                  fall;
    logic                  frame_start;
    logic                  accept;
    logic [FrameLen-1:0]   load_frame;

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  lrclk_q, lrclk_d;
    logic                  data_q, data_d;
    logic                  word_end_q, word_end_d;
    logic                  underrun_q, underrun_d;
    logic                  hold_empty_q, hold_empty_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
    logic [FrameLen-1:0]   shift_q, shift_d;
    logic                  last_lsb_q, last_lsb_d;

    i2s_bclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_bclk_gen (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .bclk_o        (i2s_bclk_o),
        .bclk_posedge_o(bclk_posedge_o),
        .bclk_negedge_o(bclk_negedge_o),
        .fall_next_o   (fall)
    );

    always_comb begin
        frame_start  = fall && (cnt_q == CntLast);
        accept       = data_val_i && hold_empty_q;
        load_frame   = hold_empty_q ? '0 : {hold_l_q, hold_r_q};

        cnt_d        = cnt_q;
        lrclk_d      = lrclk_q;
        data_d       = data_q;
        word_end_d   = 1'b0;
        underrun_d   = 1'b0;
        hold_empty_d = hold_empty_q;
        hold_l_d     = hold_l_q;
        hold_r_d     = hold_r_q;
        shift_d      = shift_q;
        last_lsb_d   = last_lsb_q;

        if (fall) begin
            cnt_d      = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
            lrclk_d    = (cnt_d >= CntHalf);
            word_end_d = (cnt_d == '0) || (cnt_d == CntHalf);
            data_d     = shift_q[FrameLen-1];
            shift_d    = shift_q << 1;
        end

        if (frame_start) begin
            hold_empty_d = 1'b1;
            underrun_d   = hold_empty_q;
            last_lsb_d   = load_frame[0];
            // Philips format emits the previous right LSB first, delaying the word by one bit.
            if (I2S_FORMAT == I2S_FMT_PHILIPS) begin
                data_d  = last_lsb_q;
                shift_d = load_frame;
            end else begin
                data_d  = load_frame[FrameLen-1];
                shift_d = load_frame << 1;
            end
        end

        if (accept) begin
            hold_l_d     = left_i;
            hold_r_d     = right_i;
            hold_empty_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q        <= CntLast;
            lrclk_q      <= 1'b1;
            data_q       <= 1'b0;
            word_end_q   <= 1'b0;
            underrun_q   <= 1'b0;
            hold_empty_q <= 1'b1;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
            shift_q      <= '0;
            last_lsb_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            lrclk_q      <= lrclk_d;
            data_q       <= data_d;
            word_end_q   <= word_end_d;
            underrun_q   <= underrun_d;
            hold_empty_q <= hold_empty_d;
            hold_l_q     <= hold_l_d;
            hold_r_q     <= hold_r_d;
            shift_q      <= shift_d;
            last_lsb_q   <= last_lsb_d;
        end
    end

    assign data_rdy_o  = hold_empty_q;
    assign i2s_lrclk_o = lrclk_q;
    assign i2s_data_o  = data_q;
    assign word_end_o  = word_end_q;
    assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Bench: both I2S formats side by side against a frame-level model of the bit stream.
module tb_i2s_master_tx;

    localparam int DW = 16;
    localparam int CD = 2;
    localparam int P  = 2 * CD;
    localparam int FL = 2 * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] left = '0;
    logic [DW-1:0] right = '0;
    logic          val = 1'b0;

    logic rdy0, bclk0, lr0, d0, pe0, ne0, we0, ur0;
    logic rdy1, bclk1, lr1, d1, pe1, ne1, we1, ur1;

    i2s_master_tx #(.DATA_WIDTH(DW), .I2S_FORMAT(0), .CLK_DIV(CD)) u_lj (
        .clk_i(clk), .rst_i(rst), .left_i(left), .right_i(right), .data_val_i(val),
        .data_rdy_o(rdy0), .i2s_bclk_o(bclk0), .i2s_lrclk_o(lr0), .i2s_data_o(d0),
        .bclk_posedge_o(pe0), .bclk_negedge_o(ne0), .word_end_o(we0), .underrun_o(ur0)
    );

    i2s_master_tx #(.DATA_WIDTH(DW), .I2S_FORMAT(1), .CLK_DIV(CD)) u_ph (
        .clk_i(clk), .rst_i(rst), .left_i(left), .right_i(right), .data_val_i(val),
        .data_rdy_o(rdy1), .i2s_bclk_o(bclk1), .i2s_lrclk_o(lr1), .i2s_data_o(d1),
        .bclk_posedge_o(pe1), .bclk_negedge_o(ne1), .word_end_o(we1), .underrun_o(ur1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ur_seen = 0;

    // Model: n = clock edges since reset release; frame content chosen at each frame start.
    int          n = 0;
    bit          m_full = 0;
    logic [15:0] m_hl = '0, m_hr = '0, m_cl = '0, m_cr = '0, m_pr = '0;
    bit          m_cur_ur = 0;

    function automatic int cnt_of(input int nn);
        int f;
        f = nn / P;
        return (f == 0) ? FL - 1 : (f - 1) % FL;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_bclk0"}, bclk0, 0);   chk({tag, "_bclk1"}, bclk1, 0);
        chk({tag, "_lr0"}, lr0, 1);       chk({tag, "_lr1"}, lr1, 1);
        chk({tag, "_d0"}, d0, 0);         chk({tag, "_d1"}, d1, 0);
        chk({tag, "_pe0"}, pe0, 0);       chk({tag, "_pe1"}, pe1, 0);
        chk({tag, "_ne0"}, ne0, 0);       chk({tag, "_ne1"}, ne1, 0);
        chk({tag, "_we0"}, we0, 0);       chk({tag, "_we1"}, we1, 0);
        chk({tag, "_ur0"}, ur0, 0);       chk({tag, "_ur1"}, ur1, 0);
        chk({tag, "_rdy0"}, rdy0, 1);     chk({tag, "_rdy1"}, rdy1, 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        bit acc;
        @(posedge clk or posedge rst);
        if (rst) begin
            n = 0; m_full = 0; m_cur_ur = 0;
            m_hl = '0; m_hr = '0; m_cl = '0; m_cr = '0; m_pr = '0;
        end else begin
            acc = val && !m_full;
            n = n + 1;
            if (n % P == 0 && cnt_of(n) == 0) begin
                m_pr = m_cr;
                if (m_full) begin
                    m_cl = m_hl; m_cr = m_hr; m_full = 0; m_cur_ur = 0;
                end else begin
                    m_cl = '0; m_cr = '0; m_cur_ur = 1;
                end
            end
            if (acc) begin
                m_hl = left; m_hr = right; m_full = 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        int c;
        bit neg, e0, e1;
        @(negedge clk);
        if (rst) begin
            chk_reset("rst");
        end else begin
            c   = cnt_of(n);
            neg = (n % P == 0);
            e0  = (c < DW) ? m_cl[DW-1-c] : m_cr[FL-1-c];
            e1  = (c == 0) ? m_pr[0] : (c <= DW) ? m_cl[DW-c] : m_cr[FL-c];
            chk("bclk0", bclk0, (n / CD) % 2);  chk("bclk1", bclk1, (n / CD) % 2);
            chk("pe0", pe0, (n % P == CD));     chk("pe1", pe1, (n % P == CD));
            chk("ne0", ne0, neg);               chk("ne1", ne1, neg);
            chk("lr0", lr0, (c >= DW));         chk("lr1", lr1, (c >= DW));
            chk("we0", we0, neg && (c == 0 || c == DW));
            chk("we1", we1, neg && (c == 0 || c == DW));
            chk("ur0", ur0, neg && c == 0 && m_cur_ur);
            chk("ur1", ur1, neg && c == 0 && m_cur_ur);
            chk("rdy0", rdy0, !m_full);         chk("rdy1", rdy1, !m_full);
            chk("data_lj", d0, e0);             chk("data_ph", d1, e1);
            if (ur0) ur_seen++;
        end
    end

    task automatic send(input logic [15:0] l, input logic [15:0] r, output int t_acc);
        bit ok;
        ok = 0;
        t_acc = -1;
        left = l; right = r; val = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (rdy0) begin
                @(posedge clk);
                #1;
                t_acc = cyc;
                ok = 1;
            end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: got no data_rdy_o expected accept within 400 cycles");
        end
    endtask

    task automatic wait_cnt(input int target);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (cnt_of(n) == target) ok = 1;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_cnt: got timeout expected count %0d", target);
        end
    endtask

    initial begin
        int pe_t[$];
        int lf_t[$];
        int acc_t[3];
        int t, rel, ur_a, ur_b, wec;
        bit prev_lr, found;
        logic [31:0] s0, s1, sl, exp1;
        logic [15:0] pl[3];
        logic [15:0] pr[3];

        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        rel = cyc;

        // Idle: no data ever offered.
        prev_lr = 1; ur_a = 0;
        repeat (300) begin
            @(negedge clk);
            if (pe0) pe_t.push_back(cyc);
            if (prev_lr && !lr0) lf_t.push_back(cyc);
            prev_lr = lr0;
            if (ur0) ur_a++;
        end
        chk("bclk_period", (pe_t.size() >= 2) ? pe_t[1] - pe_t[0] : -1, 4);
        chk("first_bclk_rise", (pe_t.size() >= 1) ? pe_t[0] - rel : -1, CD);
        chk("first_frame", (lf_t.size() >= 1) ? lf_t[0] - rel : -1, 2 * CD);
        chk("lrclk_period", (lf_t.size() >= 2) ? lf_t[1] - lf_t[0] : -1, 128);
        chk("idle_underruns", ur_a, 3);

        // Directed pair, captured on BCLK rising strobes.
        send(16'hA5C3, 16'h1234, t);
        val = 1'b0;
        ur_b = ur_seen;
        prev_lr = lr0; found = 0; wec = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (prev_lr && !lr0) found = 1;
            prev_lr = lr0;
        end
        chk("frame_found", found, 1);
        if (we1) wec++;
        s0 = '0; s1 = '0; sl = '0;
        for (int b = 0, i = 0; b < 32 && i < 400; i++) begin
            @(negedge clk);
            if (we1) wec++;
            if (pe0) begin
                s0 = {s0[30:0], d0}; s1 = {s1[30:0], d1}; sl = {sl[30:0], lr0};
                b++;
            end
        end
        exp1 = {1'b0, 16'hA5C3, 15'h091A};
        chk("lj_stream", s0, 32'hA5C31234);
        chk("ph_stream", s1, exp1);
        chk("lrclk_slots", sl, 32'h0000FFFF);
        chk("ph_word_ends", wec, 2);
        chk("directed_underrun", ur_seen - ur_b, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (pe1) begin
                found = 1;
                chk("ph_next_cnt0", d1, 0);
            end
        end
        chk("next_rise_found", found, 1);

        // Back-to-back: data_val_i stays high across three pairs.
        pl[0] = 16'h1111; pr[0] = 16'hAAAA;
        pl[1] = 16'h2222; pr[1] = 16'h5555;
        pl[2] = 16'h7E81; pr[2] = 16'h8001;
        ur_b = ur_seen;
        for (int k = 0; k < 3; k++) send(pl[k], pr[k], acc_t[k]);
        val = 1'b0;
        repeat (130) @(negedge clk);
        chk("b2b_gap", acc_t[2] - acc_t[1], 128);
        chk("b2b_underruns", ur_seen - ur_b, 0);

        // Random pairs with random idle gaps.
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(0, 300)) @(negedge clk);
            send(16'($urandom), 16'($urandom), t);
            val = 1'b0;
        end
        repeat (300) @(negedge clk);

        // Asynchronous reset mid-frame with the holding register full.
        wait_cnt(0);
        send(16'hBEEF, 16'hCAFE, t);
        val = 1'b0;
        wait_cnt(20);
        #2 rst = 1'b1;
        #1 chk_reset("async");
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        ur_b = ur_seen;
        repeat (10) @(negedge clk);
        chk("post_reset_underrun", ur_seen - ur_b, 1);
        repeat (200) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
